ov7670_config_sequencer: RTL and testbench

// - Upstream stage of the OV7670 SCCB register writer. Walks a constant table of
//   {reg_addr, reg_data} pairs and issues one SCCB write per entry through the

---
 rtl/ov7670_pkg.sv | 25 ++
 rtl/ov7670_config_rom.sv | 47 ++++
 rtl/ov7670_config_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_ov7670_config_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 configuration sequencer and its register table.
package ov7670_pkg;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } ov7670_reg_t;

    localparam logic [7:0]  REG_COM7  = 8'h12;
    localparam logic [15:0] REG_END   = 16'hFFFF;
    localparam logic [15:0] REG_DELAY = 16'hFFF0;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_PWRUP     = 4'd1,
        ST_FETCH     = 4'd2,
        ST_DECODE    = 4'd3,
        ST_ISSUE     = 4'd4,
        ST_WAIT_ACK  = 4'd5,
        ST_WAIT_DONE = 4'd6,
        ST_DELAY     = 4'd7,
        ST_DONE      = 4'd8
    } cfg_state_e;

endpackage

// File: rtl/ov7670_config_rom.sv
// Constant OV7670 register table: soft reset, settle delay, RGB565/VGA setup, end marker.
module ov7670_config_rom
    import ov7670_pkg::*;
#(
    parameter int unsigned TABLE_DEPTH = 128
) (
    input  logic [$clog2(TABLE_DEPTH)-1:0] index,
    output ov7670_reg_t                    entry
);

    logic [31:0] idx;

    assign idx = 32'(index);

    always_comb begin
        entry = ov7670_reg_t'(REG_END);
        case (idx)
            0:  entry = '{addr: REG_COM7, data: 8'h80};
            1:  entry = ov7670_reg_t'(REG_DELAY);
            2:  entry = '{addr: REG_COM7, data: 8'h04};
            3:  entry = '{addr: 8'h11, data: 8'h00};
            4:  entry = '{addr: 8'h0C, data: 8'h00};
            5:  entry = '{addr: 8'h3E, data: 8'h00};
            6:  entry = '{addr: 8'h8C, data: 8'h00};
            7:  entry = '{addr: 8'h04, data: 8'h00};
            8:  entry = '{addr: 8'h40, data: 8'hD0};
            9:  entry = '{addr: 8'h3A, data: 8'h04};
            10: entry = '{addr: 8'h14, data: 8'h18};
            11: entry = '{addr: 8'h4F, data: 8'hB3};
            12: entry = '{addr: 8'h50, data: 8'hB3};
            13: entry = '{addr: 8'h51, data: 8'h00};
            14: entry = '{addr: 8'h52, data: 8'h3D};
            15: entry = '{addr: 8'h53, data: 8'hA7};
            16: entry = '{addr: 8'h54, data: 8'hE4};
            17: entry = '{addr: 8'h58, data: 8'h9E};
            18: entry = '{addr: 8'h3D, data: 8'hC0};
            19: entry = '{addr: 8'h17, data: 8'h14};
            20: entry = '{addr: 8'h18, data: 8'h02};
            21: entry = '{addr: 8'h32, data: 8'h80};
            22: entry = '{addr: 8'h19, data: 8'h03};
            23: entry = '{addr: 8'h1A, data: 8'h7B};
            24: entry = '{addr: 8'h03, data: 8'h0A};
            default: entry = ov7670_reg_t'(REG_END);
        endcase
    end

endmodule

// File: rtl/ov7670_config_sequencer.sv
// Walks the OV7670 register table and issues one SCCB write per entry via the writer handshake.
// Optional OV7670_CFG_OVERRIDE_EN adds a single-write override port usable while idle.
module ov7670_config_sequencer
    import ov7670_pkg::*;
#(
    parameter int unsigned CLK_FREQ         = 25000000,
    parameter int unsigned POWERUP_DELAY_MS = 1,
    parameter int unsigned MARKER_DELAY_MS  = 10,
    parameter int unsigned TABLE_DEPTH      = 128
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cfg_start,
    input  logic                           sccb_ready,
`ifdef OV7670_CFG_OVERRIDE_EN
    input  logic                           ovr_valid,
    input  logic [7:0]                     ovr_address,
    input  logic [7:0]                     ovr_data,
    output logic                           ovr_ready,
`endif
    output logic                           sccb_start,
    output logic [7:0]                     sccb_address,
    output logic [7:0]                     sccb_data,
    output logic                           cfg_busy,
    output logic                           cfg_done,
    output logic [$clog2(TABLE_DEPTH)-1:0] cfg_index
);

    localparam int unsigned IDX_W       = $clog2(TABLE_DEPTH);
    localparam logic [31:0] POWERUP_CYC = 32'((CLK_FREQ / 1000) * POWERUP_DELAY_MS);
    localparam logic [31:0] MARKER_CYC  = 32'((CLK_FREQ / 1000) * MARKER_DELAY_MS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TABLE_DEPTH - 1);

    cfg_state_e       state, state_next;
    logic [31:0]      cnt, cnt_next;
    logic [IDX_W-1:0] index_next;
    ov7670_reg_t      entry_q, entry_next, rom_entry, ovr_entry;
    logic             start_next, busy_next, done_next;
    logic [7:0]       addr_next, data_next;
    logic             ovr_mode, ovr_mode_next, ovr_req, advance;

    ov7670_config_rom #(
        .TABLE_DEPTH(TABLE_DEPTH)
    ) u_rom (
        .index(cfg_index),
        .entry(rom_entry)
    );

`ifdef OV7670_CFG_OVERRIDE_EN
    // Override handshake is open only while the sequencer sits idle.
    always_ff @(posedge clk) begin
        if (!rst_n) ovr_ready <= 1'b1;
        else        ovr_ready <= (state_next == ST_IDLE);
    end
    assign ovr_req   = ovr_valid && ovr_ready;
    assign ovr_entry = '{addr: ovr_address, data: ovr_data};
`else
    assign ovr_req   = 1'b0;
    assign ovr_entry = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= 32'd0;
            cfg_index    <= '0;
            entry_q      <= '0;
            sccb_start   <= 1'b0;
            sccb_address <= 8'd0;
            sccb_data    <= 8'd0;
            cfg_busy     <= 1'b0;
            cfg_done     <= 1'b0;
            ovr_mode     <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            cfg_index    <= index_next;
            entry_q      <= entry_next;
            sccb_start   <= start_next;
            sccb_address <= addr_next;
            sccb_data    <= data_next;
            cfg_busy     <= busy_next;
            cfg_done     <= done_next;
            ovr_mode     <= ovr_mode_next;
        end
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        index_next    = cfg_index;
        entry_next    = entry_q;
        start_next    = 1'b0;
        addr_next     = sccb_address;
        data_next     = sccb_data;
        done_next     = cfg_done;
        ovr_mode_next = ovr_mode;
        advance       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (cfg_start) begin
                    cnt_next      = POWERUP_CYC;
                    done_next     = 1'b0;
                    index_next    = '0;
                    ovr_mode_next = 1'b0;
                    state_next    = ST_PWRUP;
                end else if (ovr_req) begin
                    addr_next     = ovr_entry.addr;
                    data_next     = ovr_entry.data;
                    ovr_mode_next = 1'b1;
                    state_next    = ST_ISSUE;
                end
            end
            ST_PWRUP: begin
                if (cnt == 32'd0) state_next = ST_FETCH;
                else              cnt_next   = cnt - 32'd1;
            end
            ST_FETCH: begin
                entry_next = rom_entry;
                state_next = ST_DECODE;
            end
            ST_DECODE: begin
                if (entry_q == REG_END) begin
                    state_next = ST_DONE;
                end else if (entry_q == REG_DELAY) begin
                    cnt_next   = MARKER_CYC;
                    state_next = ST_DELAY;
                end else begin
                    addr_next  = entry_q.addr;
                    data_next  = entry_q.data;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (sccb_ready) begin
                    start_next = 1'b1;
                    state_next = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (!sccb_ready) state_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (sccb_ready) begin
                    if (ovr_mode) begin
                        ovr_mode_next = 1'b0;
                        state_next    = ST_IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            ST_DELAY: begin
                if (cnt == 32'd0) advance  = 1'b1;
                else              cnt_next = cnt - 32'd1;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Running off the end of the table without an end marker finishes the sequence.
        if (advance) begin
            if (cfg_index == LAST_IDX) begin
                state_next = ST_DONE;
            end else begin
                index_next = cfg_index + IDX_W'(1);
                state_next = ST_FETCH;
            end
        end

        if (state_next == ST_DONE) done_next = 1'b1;
        busy_next = (state_next != ST_IDLE) && (state_next != ST_DONE);
    end

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Directed self-checking bench for ov7670_config_sequencer with a behavioural SCCB writer model.
module tb_ov7670_config_sequencer;

    localparam int unsigned CLK_FREQ = 100000;
    localparam int unsigned N_WRITES = 24;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_start = 1'b0;
    logic       hold = 1'b0;
    logic       wr_ready = 1'b1;
    int         wr_cnt = 0;
    logic       sccb_ready;
    logic       sccb_start;
    logic [7:0] sccb_address, sccb_data;
    logic       cfg_busy, cfg_done;
    logic [6:0] cfg_index;
`ifdef OV7670_CFG_OVERRIDE_EN
    logic       ovr_valid = 1'b0;
    logic [7:0] ovr_address = 8'd0;
    logic [7:0] ovr_data = 8'd0;
    logic       ovr_ready;
`endif

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int starts = 0;
    int last_rise = 0;
    logic prev_start = 1'b0;
    logic prev_ready = 1'b1;
    logic in_txn = 1'b0;
    logic [7:0] lat_addr = 8'd0, lat_data = 8'd0;
    logic [7:0] q_addr[$];
    logic [7:0] q_data[$];
    int q_cyc[$];
    int q_gap[$];
    int base, rel;

    assign sccb_ready = wr_ready && !hold;

    ov7670_config_sequencer #(
        .CLK_FREQ(CLK_FREQ),
        .POWERUP_DELAY_MS(1),
        .MARKER_DELAY_MS(10),
        .TABLE_DEPTH(128)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg_start(cfg_start),
        .sccb_ready(sccb_ready),
`ifdef OV7670_CFG_OVERRIDE_EN
        .ovr_valid(ovr_valid),
        .ovr_address(ovr_address),
        .ovr_data(ovr_data),
        .ovr_ready(ovr_ready),
`endif
        .sccb_start(sccb_start),
        .sccb_address(sccb_address),
        .sccb_data(sccb_data),
        .cfg_busy(cfg_busy),
        .cfg_done(cfg_done),
        .cfg_index(cfg_index)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Writer: ready drops the cycle after start, returns 20 cycles later; no reset.
    always @(posedge clk) begin
        if (sccb_start) begin
            wr_ready <= 1'b0;
            wr_cnt   <= 20;
        end else if (wr_cnt > 0) begin
            wr_cnt <= wr_cnt - 1;
            if (wr_cnt == 1) wr_ready <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(cfg_busy), 0);
        chk({tag, "_done"}, 32'(cfg_done), 0);
        chk({tag, "_start"}, 32'(sccb_start), 0);
        chk({tag, "_addr"}, 32'(sccb_address), 0);
        chk({tag, "_data"}, 32'(sccb_data), 0);
        chk({tag, "_index"}, 32'(cfg_index), 0);
    endtask

    // Request monitor: pulse width, per-request log, addr/data stability while ready is low.
    always @(negedge clk) begin
        if (sccb_ready && !prev_ready) last_rise = cyc;
        if (!cfg_busy) in_txn = 1'b0;
        if (sccb_start) begin
            chk("start_one_cycle", 32'(prev_start), 0);
            starts++;
            q_addr.push_back(sccb_address);
            q_data.push_back(sccb_data);
            q_cyc.push_back(cyc);
            q_gap.push_back(cyc - last_rise);
            in_txn   = 1'b1;
            lat_addr = sccb_address;
            lat_data = sccb_data;
        end else if (in_txn && !sccb_ready) begin
            chk("addr_stable", 32'(sccb_address), 32'(lat_addr));
            chk("data_stable", 32'(sccb_data), 32'(lat_data));
        end else if (in_txn && sccb_ready && !prev_ready) begin
            in_txn = 1'b0;
        end
        prev_start = sccb_start;
        prev_ready = sccb_ready;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Power-up wait, then the soft-reset write.
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        chk("busy_after_start", 32'(cfg_busy), 1);
        chk("done_after_start", 32'(cfg_done), 0);
        repeat (99) @(negedge clk);
        chk("no_start_in_pwrup", 32'(starts), 0);
        for (int i = 0; i < 200 && starts < 1; i++) @(negedge clk);
        chk("first_start_seen", 32'(starts), 1);
        chk("first_addr", 32'(q_addr[0]), 32'h12);
        chk("first_data", 32'(q_data[0]), 32'h80);

        // Delay marker separates the soft reset from the next write.
        for (int i = 0; i < 3000 && starts < 2; i++) @(negedge clk);
        chk("second_start_seen", 32'(starts), 2);
        chk("marker_gap_ge_1000", 32'(q_gap[1] >= 1000), 1);
        chk("second_addr", 32'(q_addr[1]), 32'h12);
        chk("second_data", 32'(q_data[1]), 32'h04);

        // Full run to the end marker.
        for (int i = 0; i < 5000 && !cfg_done; i++) @(negedge clk);
        chk("done_after_table", 32'(cfg_done), 1);
        chk("busy_after_table", 32'(cfg_busy), 0);
        chk("write_count", 32'(starts), N_WRITES);
        chk("end_index", 32'(cfg_index), 25);
        chk("mid_addr", 32'(q_addr[8]), 32'h3A);
        chk("mid_data", 32'(q_data[8]), 32'h04);
        chk("last_addr", 32'(q_addr[23]), 32'h03);
        chk("last_data", 32'(q_data[23]), 32'h0A);
        repeat (5) @(negedge clk);
        chk("done_sticky", 32'(cfg_done), 1);
        chk("idle_not_busy", 32'(cfg_busy), 0);

        // Restart from done with the writer holding ready low past power-up.
        base = starts;
        hold = 1'b1;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        chk("restart_done_cleared", 32'(cfg_done), 0);
        chk("restart_busy", 32'(cfg_busy), 1);
        repeat (152) @(negedge clk);
        chk("issue_waits_ready", 32'(starts), 32'(base));
        rel = cyc;
        hold = 1'b0;
        for (int i = 0; i < 20 && starts <= base; i++) @(negedge clk);
        chk("held_start_seen", 32'(starts), 32'(base + 1));
        chk("held_start_after_ready", 32'(q_cyc[base] > rel), 1);
        chk("held_addr", 32'(q_addr[base]), 32'h12);
        chk("held_data", 32'(q_data[base]), 32'h80);

        // Reset while the writer is mid-frame, then restart.
        for (int i = 0; i < 10 && sccb_ready; i++) @(negedge clk);
        chk("writer_busy_before_reset", 32'(sccb_ready), 0);
        rst_n = 1'b0;
        hold = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midreset");
        rst_n = 1'b1;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        base = starts;
        repeat (150) @(negedge clk);
        chk("reset_restart_waits", 32'(starts), 32'(base));
        hold = 1'b0;
        for (int i = 0; i < 20 && starts <= base; i++) @(negedge clk);
        chk("reset_restart_addr", 32'(q_addr[base]), 32'h12);
        chk("reset_restart_data", 32'(q_data[base]), 32'h80);
        for (int i = 0; i < 5000 && !cfg_done; i++) @(negedge clk);
        chk("reset_restart_done", 32'(cfg_done), 1);
        chk("reset_restart_count", 32'(starts - base), N_WRITES);

`ifdef OV7670_CFG_OVERRIDE_EN
        // Single override write after done.
        @(negedge clk);
        chk("ovr_ready_idle", 32'(ovr_ready), 1);
        base = starts;
        ovr_valid = 1'b1;
        ovr_address = 8'h3A;
        ovr_data = 8'h04;
        @(negedge clk);
        ovr_valid = 1'b0;
        chk("ovr_busy", 32'(cfg_busy), 1);
        chk("ovr_ready_busy", 32'(ovr_ready), 0);
        for (int i = 0; i < 100 && cfg_busy; i++) @(negedge clk);
        chk("ovr_one_write", 32'(starts - base), 1);
        chk("ovr_addr", 32'(q_addr[base]), 32'h3A);
        chk("ovr_data", 32'(q_data[base]), 32'h04);
        chk("ovr_done_kept", 32'(cfg_done), 1);
        chk("ovr_index_kept", 32'(cfg_index), 25);
        @(negedge clk);
        chk("ovr_ready_back", 32'(ovr_ready), 1);
`endif

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
